// File: rtl/snake_pkg.sv
// Shared encodings, default timing and small helpers for the snake input path.
package snake_pkg;

    // Snake heading encoding.
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    // Debouncer states.
    typedef enum logic [1:0] {
        DB_IDLE         = 2'b00,
        DB_WAIT_PRESS   = 2'b01,
        DB_PRESSED      = 2'b10,
        DB_WAIT_RELEASE = 2'b11
    } db_state_e;

    // Defaults for a 100 MHz clock: 5 ms debounce, 150 ms move period.
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_MOVE_PERIOD     = 15000000;

    // Counter width for a modulo-n counter, never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Fixed-priority pick among simultaneous presses {U,R,D,L}: U > R > D > L.
    function automatic dir_e pick_dir(input logic [3:0] p);
        dir_e d;
        if (p[3])      d = DIR_UP;
        else if (p[2]) d = DIR_RIGHT;
        else if (p[1]) d = DIR_DOWN;
        else           d = DIR_LEFT;
        return d;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a four-state debouncer; emits a one-cycle
// pulse when a press is accepted.
module btn_debounce
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          btn_s;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    assign btn_s       = sync_q[1];
    assign press_pulse = pulse_q;

    // Synchroniser shift and debounce next-state / counter / pulse.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            DB_IDLE: begin
                if (btn_s) begin
                    state_d = DB_WAIT_PRESS;
                    cnt_d   = '0;
                end
            end
            DB_WAIT_PRESS: begin
                if (!btn_s) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Only this path counts as an accepted press; a bounce
                    // back from WAIT_RELEASE must not pulse again.
                    state_d = DB_PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DB_PRESSED: begin
                if (!btn_s) begin
                    state_d = DB_WAIT_RELEASE;
                    cnt_d   = '0;
                end
            end
            DB_WAIT_RELEASE: begin
                if (btn_s) begin
                    state_d = DB_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = DB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset aborts any debounce in progress.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q  <= '0;
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

endmodule

// File: rtl/snake_input_ctrl.sv
// Button front end for the snake game: debounced presses feed a pending
// heading that is committed to Dir only on the periodic move tick.
module snake_input_ctrl
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int MOVE_PERIOD     = DEF_MOVE_PERIOD
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       BtnU,
    input  logic       BtnR,
    input  logic       BtnD,
    input  logic       BtnL,
    input  logic       Run,
    output logic [1:0] Dir,
    output logic       MoveTick,
    output logic [3:0] PressPulse
);

    localparam int            TW        = cnt_width(MOVE_PERIOD);
    localparam logic [TW-1:0] TICK_LAST = TW'(MOVE_PERIOD - 1);

    logic [3:0]    btn_raw;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    dir_e          dir_q, dir_d;
    dir_e          pend_dir_q, pend_dir_d;
    logic          pend_valid_q, pend_valid_d;
    logic          run_q, run_d;
    dir_e          press_dir;

    assign btn_raw = {BtnU, BtnR, BtnD, BtnL};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .Clk        (Clk),
            .Reset_n    (Reset_n),
            .btn_raw    (btn_raw[g]),
            .press_pulse(PressPulse[g])
        );
    end

    assign Dir      = dir_q;
    assign MoveTick = Run && (tick_cnt_q == TICK_LAST);

    // Move-period counter: free-runs only while Run, parked at 0 otherwise.
    always_comb begin
        tick_cnt_d = '0;
        if (Run && (tick_cnt_q != TICK_LAST)) tick_cnt_d = tick_cnt_q + TW'(1);
    end

    // Heading bookkeeping: commit on tick, then latch a new press, then
    // let a Run falling edge override everything for the next game.
    always_comb begin
        dir_d        = dir_q;
        pend_dir_d   = pend_dir_q;
        pend_valid_d = pend_valid_q;
        run_d        = Run;
        press_dir    = pick_dir(PressPulse);
        if (MoveTick) begin
            if (pend_valid_q) dir_d = pend_dir_q;
            pend_valid_d = 1'b0;
        end
        // Reversal check uses the pre-commit heading, so a press in the tick
        // cycle is judged against the heading that is still on screen.
        if ((|PressPulse) && ((press_dir ^ dir_q) != 2'b10)) begin
            pend_dir_d   = press_dir;
            pend_valid_d = 1'b1;
        end
        if (run_q && !Run) begin
            dir_d        = DIR_RIGHT;
            pend_valid_d = 1'b0;
        end
    end

    // Registers for tick counter and heading state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tick_cnt_q   <= '0;
            dir_q        <= DIR_RIGHT;
            pend_dir_q   <= DIR_RIGHT;
            pend_valid_q <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            dir_q        <= dir_d;
            pend_dir_q   <= pend_dir_d;
            pend_valid_q <= pend_valid_d;
            run_q        <= run_d;
        end
    end

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Bench for snake_input_ctrl: directed scenarios plus random button/Run
// traffic, all checked against a level/run-length behavioural model.
module tb_snake_input_ctrl;
    import snake_pkg::*;

    localparam int D = 4;
    localparam int P = 20;

    logic       Clk, Reset_n, BtnU, BtnR, BtnD, BtnL, Run;
    logic [1:0] Dir;
    logic       MoveTick;
    logic [3:0] PressPulse;

    int n_vec = 0;
    int n_err = 0;
    int pcnt[4];

    // Reference model state.
    logic [1:0] m_dir, m_pend;
    bit         m_pv, m_run_prev;
    int         m_phase;
    logic [3:0] m_pulse, m_lvl, m_s1, m_s2;
    int         m_run[4];

    snake_input_ctrl #(.DEBOUNCE_CYCLES(D), .MOVE_PERIOD(P)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .BtnU(BtnU), .BtnR(BtnR), .BtnD(BtnD),
        .BtnL(BtnL), .Run(Run), .Dir(Dir), .MoveTick(MoveTick), .PressPulse(PressPulse)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dir = DIR_RIGHT; m_pend = DIR_RIGHT; m_pv = 0; m_run_prev = 0; m_phase = 0;
        m_pulse = '0; m_lvl = '0; m_s1 = '0; m_s2 = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
    endtask

    // One rising edge of the reference model, using pre-edge inputs.
    task automatic model_edge();
        logic [3:0] raw, np;
        logic [1:0] old, win;
        bit tick, found;
        if (!Reset_n) begin model_reset(); return; end
        raw  = {BtnU, BtnR, BtnD, BtnL};
        tick = Run && (m_phase == P - 1);
        old  = m_dir;
        if (tick) begin
            if (m_pv) m_dir = m_pend;
            m_pv = 0;
        end
        found = 0; win = 2'b00;
        for (int i = 3; i >= 0; i--)
            if (!found && m_pulse[i]) begin found = 1; win = 2'(3 - i); end
        if (found && ((win ^ old) != 2'b10)) begin m_pend = win; m_pv = 1; end
        if (m_run_prev && !Run) begin m_dir = DIR_RIGHT; m_pv = 0; end
        m_phase    = Run ? (m_phase + 1) % P : 0;
        m_run_prev = Run;
        // Accepted level flips after D+1 consecutive samples at the other level.
        np = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == D + 1) begin
                    m_lvl[i] = m_s2[i];
                    m_run[i] = 0;
                    np[i]    = m_s2[i];
                end
            end else m_run[i] = 0;
        end
        m_s2 = m_s1;
        m_s1 = raw;
        m_pulse = np;
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        chk("dir", Dir, m_dir);
        chk("tick", MoveTick, Run && (m_phase == P - 1));
        chk("press", PressPulse, m_pulse);
        for (int i = 0; i < 4; i++) if (PressPulse[i]) pcnt[i]++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_btn(input logic [3:0] m);
        {BtnU, BtnR, BtnD, BtnL} = m;
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        set_btn(m);
        cycles(hold);
        set_btn(4'b0000);
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        while (!MoveTick && n < 2 * P) begin step(); n++; end
        chk(tag, MoveTick, 1);
    endtask

    task automatic clear_pcnt();
        for (int i = 0; i < 4; i++) pcnt[i] = 0;
    endtask

    initial begin
        int n;
        Clk = 0; Reset_n = 0; Run = 0;
        set_btn(4'b0000);
        model_reset();
        clear_pcnt();

        // Reset state
        cycles(3);
        chk("rst_dir", Dir, DIR_RIGHT);
        chk("rst_tick", MoveTick, 0);
        chk("rst_press", PressPulse, 0);
        Reset_n = 1;
        cycles(2);

        // Run rises: the first tick lands in the P-th cycle with Run high
        // (the rise cycle being the first), then every P cycles.
        Run = 1; n = 0;
        do begin step(); n++; end while (!MoveTick && n < 3 * P);
        chk("first_tick", n, P - 1);
        n = 0;
        do begin step(); n++; end while (!MoveTick && n < 3 * P);
        chk("tick_period", n, P);
        chk("idle_dir", Dir, DIR_RIGHT);

        // Short R glitch rejected; held D gives exactly one pulse.
        step(); clear_pcnt();
        press(4'b0100, 3);
        cycles(12);
        chk("short_r_pulses", pcnt[2], 0);
        wait_tick("tick_a"); step(); clear_pcnt();
        press(4'b0010, 10);
        cycles(4);
        chk("held_d_pulses", pcnt[1], 1);
        wait_tick("tick_b"); step();
        chk("dir_down", Dir, DIR_DOWN);

        // New game: reversal L discarded; U then L before a tick -> UP.
        Run = 0; step(); Run = 1;
        wait_tick("tick_c"); step(); clear_pcnt();
        press(4'b0001, 8); cycles(8);
        chk("l_pulse", pcnt[0], 1);
        wait_tick("tick_d"); step();
        chk("rev_discard", Dir, DIR_RIGHT);
        press(4'b1000, 6);
        press(4'b0001, 6);
        wait_tick("tick_e"); step();
        chk("u_then_l", Dir, DIR_UP);
        press(4'b0001, 6);
        wait_tick("tick_f"); step();
        chk("l_next_tick", Dir, DIR_LEFT);

        // Simultaneous U and D with heading RIGHT: U wins.
        Run = 0; step(); Run = 1;
        wait_tick("tick_g"); step();
        press(4'b1010, 6);
        wait_tick("tick_h"); step();
        chk("u_over_d", Dir, DIR_UP);

        // Press accepted in the tick cycle: L commits now, R next tick.
        wait_tick("tick_i"); step();
        press(4'b0001, 6);
        cycles(6);
        set_btn(4'b0100); cycles(6); set_btn(4'b0000);
        step();
        chk("tick_coincide", MoveTick, 1);
        chk("press_coincide", PressPulse, 4'b0100);
        step();
        chk("commit_unchanged", Dir, DIR_LEFT);
        wait_tick("tick_j"); step();
        chk("late_press_applied", Dir, DIR_RIGHT);

        // Reset mid-period with a pending UP.
        press(4'b1000, 6); cycles(3);
        Reset_n = 0; #1;
        model_reset();
        chk("mid_rst_dir", Dir, DIR_RIGHT);
        chk("mid_rst_tick", MoveTick, 0);
        chk("mid_rst_press", PressPulse, 0);
        cycles(3);
        Reset_n = 1; n = 0;
        do begin step(); n++; end while (!MoveTick && n < 3 * P);
        chk("post_rst_tick", n, P - 1);
        step();
        chk("post_rst_dir", Dir, DIR_RIGHT);

        // Random buttons, Run toggles and one asynchronous reset.
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 99) == 0) Run = ~Run;
            if ($urandom_range(0, 5) == 0) set_btn(4'($urandom_range(0, 15)));
            if (c == 250) begin
                Reset_n = 0; #1;
                model_reset();
                chk("rnd_rst_dir", Dir, DIR_RIGHT);
                chk("rnd_rst_press", PressPulse, 0);
                cycles(2);
                Reset_n = 1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
